// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Memory-wait FSM state encoding, forwarding-select codes and the PC register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE    = 2'b00,
    MEM_WAIT    = 2'b01,
    MEM_RELEASE = 2'b10
  } mem_state_t;

  localparam logic [1:0] FWD_REGFILE  = 2'b00;
  localparam logic [1:0] FWD_RESULT_W = 2'b01;
  localparam logic [1:0] FWD_ALUOUT_M = 2'b10;

  localparam int PC_REG = 15;

endpackage

// File: rtl/mem_wait_fsm.sv
// Tracks multi-cycle data-memory accesses: raises memstall while an access is pending
// and forces a one-cycle release with a sticky error flag if the access exceeds MEM_TIMEOUT.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_mem_req,
  input  logic i_mem_ready,
  output logic o_memstall,
  output logic o_mem_err
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      MEM_IDLE: begin
        if (i_mem_req && !i_mem_ready) begin
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        // A withdrawn request also ends the wait so it cannot time out spuriously.
        if (i_mem_ready || !i_mem_req) begin
          state_d = MEM_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d = MEM_RELEASE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEM_RELEASE: begin
        state_d = MEM_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = MEM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_memstall = i_mem_req && !i_mem_ready && (state_q != MEM_RELEASE);
  assign o_mem_err  = err_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the F/D/E/M/W pipeline: load-use, branch and memory-wait handling.
// Build option HAZARD_FWD_EN enables operand forwarding; without it RAW hazards stall instead.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int MEM_TIMEOUT    = 255
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [REG_ADDR_WIDTH-1:0] i_RA1_D,
  input  logic [REG_ADDR_WIDTH-1:0] i_RA2_D,
  input  logic [REG_ADDR_WIDTH-1:0] i_RA1_E,
  input  logic [REG_ADDR_WIDTH-1:0] i_RA2_E,
  input  logic [REG_ADDR_WIDTH-1:0] i_WA3_E,
  input  logic [REG_ADDR_WIDTH-1:0] i_WA3_M,
  input  logic [REG_ADDR_WIDTH-1:0] i_WA3_W,
  input  logic                      i_RegWrite_E,
  input  logic                      i_RegWrite_M,
  input  logic                      i_RegWrite_W,
  input  logic                      i_MemToReg_E,
  input  logic                      i_BranchTaken_E,
  input  logic                      i_MemReq_M,
  input  logic                      i_MemReady_M,
  output logic                      o_Stall_F,
  output logic                      o_Stall_D,
  output logic                      o_Stall_E,
  output logic                      o_Stall_M,
  output logic                      o_Flush_D,
  output logic                      o_Flush_E,
  output logic                      o_Flush_W,
  output logic [1:0]                o_ForwardA_E,
  output logic [1:0]                o_ForwardB_E,
  output logic                      o_MemErr
);

  localparam logic [REG_ADDR_WIDTH-1:0] PC_ADDR = REG_ADDR_WIDTH'(PC_REG);

  // The PC is never a valid producer, so a write to it never creates a dependency.
  function automatic logic reg_hit(input logic                      we,
                                   input logic [REG_ADDR_WIDTH-1:0] wa,
                                   input logic [REG_ADDR_WIDTH-1:0] ra);
    return we && (wa != PC_ADDR) && (wa == ra);
  endfunction

  logic memstall;
  logic load_use;
  logic data_stall;
  logic [1:0] fwd_a, fwd_b;

  mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_fsm (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_mem_req  (i_MemReq_M),
    .i_mem_ready(i_MemReady_M),
    .o_memstall (memstall),
    .o_mem_err  (o_MemErr)
  );

  assign load_use = i_MemToReg_E &&
                    (reg_hit(i_RegWrite_E, i_WA3_E, i_RA1_D) ||
                     reg_hit(i_RegWrite_E, i_WA3_E, i_RA2_D));

`ifdef HAZARD_FWD_EN
  always_comb begin
    fwd_a = FWD_REGFILE;
    fwd_b = FWD_REGFILE;
    if (reg_hit(i_RegWrite_M, i_WA3_M, i_RA1_E))      fwd_a = FWD_ALUOUT_M;
    else if (reg_hit(i_RegWrite_W, i_WA3_W, i_RA1_E)) fwd_a = FWD_RESULT_W;
    if (reg_hit(i_RegWrite_M, i_WA3_M, i_RA2_E))      fwd_b = FWD_ALUOUT_M;
    else if (reg_hit(i_RegWrite_W, i_WA3_W, i_RA2_E)) fwd_b = FWD_RESULT_W;
  end

  assign data_stall = load_use;
`else
  logic unused_fwd_inputs;

  assign fwd_a = FWD_REGFILE;
  assign fwd_b = FWD_REGFILE;
  assign unused_fwd_inputs = ^{i_RA1_E, i_RA2_E, i_WA3_W, i_RegWrite_W};

  // W-stage producers need no stall: the register file writes in the first half-cycle.
  assign data_stall = load_use ||
                      reg_hit(i_RegWrite_E, i_WA3_E, i_RA1_D) ||
                      reg_hit(i_RegWrite_E, i_WA3_E, i_RA2_D) ||
                      reg_hit(i_RegWrite_M, i_WA3_M, i_RA1_D) ||
                      reg_hit(i_RegWrite_M, i_WA3_M, i_RA2_D);
`endif

  always_comb begin
    o_Stall_F    = 1'b0;
    o_Stall_D    = 1'b0;
    o_Stall_E    = 1'b0;
    o_Stall_M    = 1'b0;
    o_Flush_D    = 1'b0;
    o_Flush_E    = 1'b0;
    o_Flush_W    = 1'b0;
    o_ForwardA_E = FWD_REGFILE;
    o_ForwardB_E = FWD_REGFILE;
    if (i_reset) begin
      o_Flush_D = 1'b1;
      o_Flush_E = 1'b1;
      o_Flush_W = 1'b1;
    end else begin
      o_ForwardA_E = fwd_a;
      o_ForwardB_E = fwd_b;
      // A memory wait freezes F..M; pending branch/load-use effects wait for the release.
      if (memstall) begin
        o_Stall_F = 1'b1;
        o_Stall_D = 1'b1;
        o_Stall_E = 1'b1;
        o_Stall_M = 1'b1;
        o_Flush_W = 1'b1;
      end else if (i_BranchTaken_E) begin
        o_Flush_D = 1'b1;
        o_Flush_E = 1'b1;
      end else if (data_stall) begin
        o_Stall_F = 1'b1;
        o_Stall_D = 1'b1;
        o_Flush_E = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expectations adapt to the HAZARD_FWD_EN build option.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Control vector order: {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W}
  localparam logic [6:0] C_NONE = 7'b0000_000;
  localparam logic [6:0] C_RST  = 7'b0000_111;
  localparam logic [6:0] C_LU   = 7'b1100_010;
  localparam logic [6:0] C_BR   = 7'b0000_110;
  localparam logic [6:0] C_MEM  = 7'b1111_001;
  localparam int         TMO    = 6;

  logic       i_clk, i_reset;
  logic [3:0] i_RA1_D, i_RA2_D, i_RA1_E, i_RA2_E, i_WA3_E, i_WA3_M, i_WA3_W;
  logic       i_RegWrite_E, i_RegWrite_M, i_RegWrite_W, i_MemToReg_E;
  logic       i_BranchTaken_E, i_MemReq_M, i_MemReady_M;
  logic       o_Stall_F, o_Stall_D, o_Stall_E, o_Stall_M;
  logic       o_Flush_D, o_Flush_E, o_Flush_W, o_MemErr;
  logic [1:0] o_ForwardA_E, o_ForwardB_E;
  logic [6:0] ctl;

  int checks = 0;
  int errors = 0;

  assign ctl = {o_Stall_F, o_Stall_D, o_Stall_E, o_Stall_M, o_Flush_D, o_Flush_E, o_Flush_W};

  pipeline_hazard_ctrl #(
    .REG_ADDR_WIDTH(4),
    .MEM_TIMEOUT   (TMO)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_RA1_D        (i_RA1_D),
    .i_RA2_D        (i_RA2_D),
    .i_RA1_E        (i_RA1_E),
    .i_RA2_E        (i_RA2_E),
    .i_WA3_E        (i_WA3_E),
    .i_WA3_M        (i_WA3_M),
    .i_WA3_W        (i_WA3_W),
    .i_RegWrite_E   (i_RegWrite_E),
    .i_RegWrite_M   (i_RegWrite_M),
    .i_RegWrite_W   (i_RegWrite_W),
    .i_MemToReg_E   (i_MemToReg_E),
    .i_BranchTaken_E(i_BranchTaken_E),
    .i_MemReq_M     (i_MemReq_M),
    .i_MemReady_M   (i_MemReady_M),
    .o_Stall_F      (o_Stall_F),
    .o_Stall_D      (o_Stall_D),
    .o_Stall_E      (o_Stall_E),
    .o_Stall_M      (o_Stall_M),
    .o_Flush_D      (o_Flush_D),
    .o_Flush_E      (o_Flush_E),
    .o_Flush_W      (o_Flush_W),
    .o_ForwardA_E   (o_ForwardA_E),
    .o_ForwardB_E   (o_ForwardB_E),
    .o_MemErr       (o_MemErr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic clr();
    i_RA1_D = 4'd0; i_RA2_D = 4'd0; i_RA1_E = 4'd0; i_RA2_E = 4'd0;
    i_WA3_E = 4'd0; i_WA3_M = 4'd0; i_WA3_W = 4'd0;
    i_RegWrite_E = 1'b0; i_RegWrite_M = 1'b0; i_RegWrite_W = 1'b0;
    i_MemToReg_E = 1'b0; i_BranchTaken_E = 1'b0;
    i_MemReq_M = 1'b0; i_MemReady_M = 1'b0;
  endtask

  task automatic next();
    @(posedge i_clk);
    #1;
    clr();
  endtask

  task automatic look();
    @(negedge i_clk);
  endtask

  initial begin
    i_reset = 1'b1;
    clr();
    look();
    check("rst_ctl", 8'(ctl), 8'(C_RST));
    check("rst_fwdA", 8'(o_ForwardA_E), 8'd0);
    check("rst_err", 8'(o_MemErr), 8'd0);
    next(); i_MemReq_M = 1'b1; i_RegWrite_M = 1'b1; i_WA3_M = 4'd2; i_RA2_E = 4'd2;
    look();
    check("rst_ctl_busy", 8'(ctl), 8'(C_RST));
    check("rst_fwdB_busy", 8'(o_ForwardB_E), 8'd0);

    next(); i_reset = 1'b0;
    look();
    check("idle_ctl", 8'(ctl), 8'(C_NONE));

    // Load-use through RA1_D, then through RA2_D, then with the PC as destination.
    next(); i_MemToReg_E = 1'b1; i_RegWrite_E = 1'b1; i_WA3_E = 4'd3; i_RA1_D = 4'd3;
    look();
    check("lu_ra1", 8'(ctl), 8'(C_LU));
    next();
    look();
    check("lu_gone", 8'(ctl), 8'(C_NONE));
    next(); i_MemToReg_E = 1'b1; i_RegWrite_E = 1'b1; i_WA3_E = 4'd3; i_RA2_D = 4'd3; i_RA1_D = 4'd1;
    look();
    check("lu_ra2", 8'(ctl), 8'(C_LU));
    next(); i_MemToReg_E = 1'b1; i_RegWrite_E = 1'b1; i_WA3_E = 4'd15; i_RA1_D = 4'd15;
    look();
    check("lu_pc", 8'(ctl), 8'(C_NONE));
    next(); i_MemToReg_E = 1'b1; i_RegWrite_E = 1'b0; i_WA3_E = 4'd3; i_RA1_D = 4'd3;
    look();
    check("lu_nowe", 8'(ctl), 8'(C_NONE));

    // ALU producer in E: forwarded when enabled, stalled otherwise.
    next(); i_RegWrite_E = 1'b1; i_WA3_E = 4'd4; i_RA2_D = 4'd4; i_RA1_D = 4'd1;
    look();
    check("alu_e_raw", 8'(ctl), FWD ? 8'(C_NONE) : 8'(C_LU));

    // M has priority over W on operand B; M producer also read by decode.
    next(); i_RegWrite_M = 1'b1; i_WA3_M = 4'd5; i_RegWrite_W = 1'b1; i_WA3_W = 4'd5;
    i_RA2_E = 4'd5; i_RA1_D = 4'd5; i_RA2_D = 4'd1; i_RA1_E = 4'd1;
    look();
    check("fwdB_mprio", 8'(o_ForwardB_E), FWD ? 8'd2 : 8'd0);
    check("fwdA_none", 8'(o_ForwardA_E), 8'd0);
    check("m_raw_d", 8'(ctl), FWD ? 8'(C_NONE) : 8'(C_LU));

    next(); i_RegWrite_W = 1'b1; i_WA3_W = 4'd7; i_RA1_E = 4'd7; i_RA1_D = 4'd7; i_RA2_D = 4'd1;
    look();
    check("fwdA_w", 8'(o_ForwardA_E), FWD ? 8'd1 : 8'd0);
    check("w_nostall", 8'(ctl), 8'(C_NONE));

    next(); i_RegWrite_M = 1'b0; i_WA3_M = 4'd5; i_RegWrite_W = 1'b1; i_WA3_W = 4'd5; i_RA2_E = 4'd5;
    look();
    check("fwdB_w_only", 8'(o_ForwardB_E), FWD ? 8'd1 : 8'd0);

    next(); i_RegWrite_M = 1'b1; i_WA3_M = 4'd15; i_RegWrite_W = 1'b1; i_WA3_W = 4'd15;
    i_RA2_E = 4'd15; i_RA1_E = 4'd15; i_RA1_D = 4'd15;
    look();
    check("fwdB_pc", 8'(o_ForwardB_E), 8'd0);
    check("fwdA_pc", 8'(o_ForwardA_E), 8'd0);
    check("pc_nostall", 8'(ctl), 8'(C_NONE));

    // Branch overrides a simultaneous load-use.
    next(); i_BranchTaken_E = 1'b1; i_MemToReg_E = 1'b1; i_RegWrite_E = 1'b1; i_WA3_E = 4'd3; i_RA1_D = 4'd3;
    look();
    check("br_over_lu", 8'(ctl), 8'(C_BR));

    // Three-cycle memory wait with a branch pending; flushes held until the ready cycle.
    for (int i = 0; i < 3; i++) begin
      next(); i_MemReq_M = 1'b1; i_BranchTaken_E = 1'b1;
      look();
      check($sformatf("memwait_%0d", i), 8'(ctl), 8'(C_MEM));
    end
    next(); i_MemReq_M = 1'b1; i_MemReady_M = 1'b1; i_BranchTaken_E = 1'b1;
    look();
    check("mem_ready_br", 8'(ctl), 8'(C_BR));
    next(); i_MemReq_M = 1'b1; i_MemReady_M = 1'b1;
    look();
    check("mem_single", 8'(ctl), 8'(C_NONE));
    check("mem_noerr", 8'(o_MemErr), 8'd0);

    // Timeout: TMO+1 stalled cycles (IDLE entry plus TMO in WAIT), then a forced release.
    for (int i = 0; i <= TMO; i++) begin
      next(); i_MemReq_M = 1'b1;
      look();
      check($sformatf("tmo_stall_%0d", i), 8'(ctl), 8'(C_MEM));
      check($sformatf("tmo_err0_%0d", i), 8'(o_MemErr), 8'd0);
    end
    next(); i_MemReq_M = 1'b1;
    look();
    check("tmo_release", 8'(ctl), 8'(C_NONE));
    check("tmo_err", 8'(o_MemErr), 8'd1);
    next(); i_MemReq_M = 1'b1;
    look();
    check("tmo_restall", 8'(ctl), 8'(C_MEM));
    check("tmo_sticky", 8'(o_MemErr), 8'd1);

    // Reset while in WAIT clears the error and returns to idle.
    next(); i_MemReq_M = 1'b1; i_reset = 1'b1;
    look();
    check("rst_wait_ctl", 8'(ctl), 8'(C_RST));
    next(); i_reset = 1'b0;
    look();
    check("rst_wait_err", 8'(o_MemErr), 8'd0);
    check("rst_wait_ctl2", 8'(ctl), 8'(C_NONE));

    // After reset the counter restarts: another full TMO+1 stall window before release.
    for (int i = 0; i <= TMO; i++) begin
      next(); i_MemReq_M = 1'b1;
      look();
      check($sformatf("tmo2_stall_%0d", i), 8'(ctl), 8'(C_MEM));
    end
    next(); i_MemReq_M = 1'b1;
    look();
    check("tmo2_release", 8'(ctl), 8'(C_NONE));
    check("tmo2_err", 8'(o_MemErr), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
